// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin scheduler sharing one 8-bit UART transmitter between NUM_REQ
//   byte producers. It accepts one byte from the winning requester, drives the
//   transmitter en/start handshake, waits for busy/done, and then holds a
//   mark-state gap before the next launch. Runs in the baud-clock domain.
//
//   Optional feature macro: UART_TX_ARB_TIMEOUT_EN
//     defined   - a frame not completed within TIMEOUT_CYCLES of its accept
//                 is aborted (txEn dropped for one cycle, timeoutErr pulse)
//     undefined - no watchdog, timeoutErr is always 0
//
// Ports:
//   clk        baud-rate clock
//   rst_n      asynchronous active-low reset
//   reqValid   per-requester byte-available flag (held until reqReady)
//   reqData    requester i byte at [8i+7:8i]
//   reqReady   one-hot, one-cycle accept pulse
//   txEn       transmitter enable (low only in reset and the abort cycle)
//   txStart    transmitter start, held until busy is seen
//   txData     byte to the transmitter, stable from accept to next accept
//   txBusy     transmitter busy
//   txDone     transmitter done
//   grantId    index of the requester whose frame is in flight
//   active     high from accept through the end of the gap
//   frameSent  one-cycle pulse when txDone is first seen for a frame
//   timeoutErr one-cycle pulse on abort (optional feature)
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned GAP_CYCLES     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         reqValid,
    input  logic [8*NUM_REQ-1:0]       reqData,
    output logic [NUM_REQ-1:0]         reqReady,
    output logic                       txEn,
    output logic                       txStart,
    output logic [7:0]                 txData,
    input  logic                       txBusy,
    input  logic                       txDone,
    output logic [$clog2(NUM_REQ)-1:0] grantId,
    output logic                       active,
    output logic                       frameSent,
    output logic                       timeoutErr
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_range
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (GAP_CYCLES > 15) begin : g_gap_range
        $error("uart_tx_arbiter: GAP_CYCLES must be in 0..15");
    end
    if (TIMEOUT_CYCLES <= 12) begin : g_timeout_range
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must exceed 12");
    end

    typedef enum logic [1:0] {IDLE, LAUNCH, SENDING, GAP} state_t;

    state_t             state, stateNxt;
    logic [IDW-1:0]     rrPtr, rrPtrNxt;
    logic               gapArmed, gapArmedNxt;
    logic [3:0]         gapCnt, gapCntNxt;

    logic               txEnNxt, txStartNxt;
    logic [7:0]         txDataNxt;
    logic [NUM_REQ-1:0] reqReadyNxt;
    logic [IDW-1:0]     grantIdNxt;
    logic               activeNxt, frameSentNxt, timeoutErrNxt;

    logic [7:0]         reqByte [NUM_REQ];
    logic               pickFound;
    logic [IDW-1:0]     pickIdx;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmoCnt, tmoCntNxt;
    logic          tmoHit;
    // Counter is cleared on the accept edge, so it reads TIMEOUT_CYCLES-1
    // on the edge that is TIMEOUT_CYCLES cycles after accept.
    assign tmoHit = (tmoCnt == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            reqByte[i] = reqData[8*i +: 8];
        end
    end

    // First set reqValid bit searching upward from rrPtr, wrapping.
    always_comb begin : rr_pick
        int unsigned cand;
        cand      = 0;
        pickFound = 1'b0;
        pickIdx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(rrPtr) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pickFound && reqValid[IDW'(cand)]) begin
                pickFound = 1'b1;
                pickIdx   = IDW'(cand);
            end
        end
    end

    always_comb begin
        stateNxt      = state;
        rrPtrNxt      = rrPtr;
        gapArmedNxt   = gapArmed;
        gapCntNxt     = gapCnt;
        txEnNxt       = 1'b1;
        txStartNxt    = txStart;
        txDataNxt     = txData;
        reqReadyNxt   = '0;
        grantIdNxt    = grantId;
        activeNxt     = active;
        frameSentNxt  = 1'b0;
        timeoutErrNxt = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
        tmoCntNxt     = tmoCnt;
`endif

        case (state)
            IDLE: begin
                // Requiring busy low here keeps a stale busy from the
                // previous frame from ever satisfying LAUNCH.
                if (!txBusy && pickFound) begin
                    reqReadyNxt[pickIdx] = 1'b1;
                    txDataNxt            = reqByte[pickIdx];
                    grantIdNxt           = pickIdx;
                    activeNxt            = 1'b1;
                    txStartNxt           = 1'b1;
                    rrPtrNxt             = (pickIdx == IDW'(NUM_REQ - 1)) ? '0 : pickIdx + 1'b1;
                    stateNxt             = LAUNCH;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    tmoCntNxt            = '0;
`endif
                end
            end

            LAUNCH: begin
                if (txBusy) begin
                    txStartNxt = 1'b0;
                    stateNxt   = SENDING;
                end
            end

            SENDING: begin
                if (txDone) begin
                    frameSentNxt = 1'b1;
                    stateNxt     = GAP;
                    gapArmedNxt  = 1'b0;
                    gapCntNxt    = '0;
                end
            end

            GAP: begin
                // gapArmed marks that busy=0 has been sampled; GAP_CYCLES
                // further edges are then counted before returning to IDLE.
                if (!gapArmed) begin
                    if (!txBusy) begin
                        if (GAP_CYCLES == 0) begin
                            activeNxt = 1'b0;
                            stateNxt  = IDLE;
                        end else begin
                            gapArmedNxt = 1'b1;
                            gapCntNxt   = '0;
                        end
                    end
                end else if (gapCnt == 4'(GAP_CYCLES - 1)) begin
                    activeNxt   = 1'b0;
                    gapArmedNxt = 1'b0;
                    stateNxt    = IDLE;
                end else begin
                    gapCntNxt = gapCnt + 1'b1;
                end
            end

            default: stateNxt = IDLE;
        endcase

`ifdef UART_TX_ARB_TIMEOUT_EN
        if (state == LAUNCH || state == SENDING) begin
            tmoCntNxt = tmoCnt + 1'b1;
        end
        // A done seen on the same edge wins over the abort.
        if (tmoHit && (state == LAUNCH || (state == SENDING && !txDone))) begin
            txEnNxt       = 1'b0;
            txStartNxt    = 1'b0;
            timeoutErrNxt = 1'b1;
            stateNxt      = GAP;
            gapArmedNxt   = 1'b0;
            gapCntNxt     = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rrPtr      <= '0;
            gapArmed   <= 1'b0;
            gapCnt     <= '0;
            txEn       <= 1'b0;
            txStart    <= 1'b0;
            txData     <= '0;
            reqReady   <= '0;
            grantId    <= '0;
            active     <= 1'b0;
            frameSent  <= 1'b0;
            timeoutErr <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmoCnt     <= '0;
`endif
        end else begin
            state      <= stateNxt;
            rrPtr      <= rrPtrNxt;
            gapArmed   <= gapArmedNxt;
            gapCnt     <= gapCntNxt;
            txEn       <= txEnNxt;
            txStart    <= txStartNxt;
            txData     <= txDataNxt;
            reqReady   <= reqReadyNxt;
            grantId    <= grantIdNxt;
            active     <= activeNxt;
            frameSent  <= frameSentNxt;
            timeoutErr <= timeoutErrNxt;
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmoCnt     <= tmoCntNxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter with NUM_REQ=4, GAP_CYCLES=3,
//   TIMEOUT_CYCLES=32, driving a small behavioural UART transmitter model
//   (IDLE samples start, START raises busy, 8 data cycles, STOP with done).
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 3;
    localparam int TMO  = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  reqValid = '0;
    logic [31:0] reqData = '0;
    logic [3:0]  reqReady;
    logic        txEn, txStart;
    logic [7:0]  txData;
    logic        txBusy = 1'b0;
    logic        txDone = 1'b0;
    logic [1:0]  grantId;
    logic        active, frameSent, timeoutErr;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ(NREQ),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .reqValid(reqValid),
        .reqData(reqData),
        .reqReady(reqReady),
        .txEn(txEn),
        .txStart(txStart),
        .txData(txData),
        .txBusy(txBusy),
        .txDone(txDone),
        .grantId(grantId),
        .active(active),
        .frameSent(frameSent),
        .timeoutErr(timeoutErr)
    );

    // Transmitter model; 'stuck' makes it sit in STOP without ever raising done.
    typedef enum logic [1:0] {M_IDLE, M_START, M_DATA, M_STOP} mst_t;
    mst_t       mst = M_IDLE;
    logic [2:0] bitcnt = '0;
    logic       stuck = 1'b0;

    always @(posedge clk) begin
        if (!txEn) begin
            mst    <= M_IDLE;
            txBusy <= 1'b0;
            txDone <= 1'b0;
            bitcnt <= '0;
        end else begin
            case (mst)
                M_IDLE: begin
                    txBusy <= 1'b0;
                    txDone <= 1'b0;
                    if (txStart) mst <= M_START;
                end
                M_START: begin
                    txBusy <= 1'b1;
                    bitcnt <= '0;
                    mst    <= M_DATA;
                end
                M_DATA: begin
                    if (bitcnt == 3'd7) begin
                        mst <= M_STOP;
                        if (!stuck) txDone <= 1'b1;
                    end else begin
                        bitcnt <= bitcnt + 3'd1;
                    end
                end
                M_STOP: begin
                    if (!txStart && !stuck) begin
                        mst    <= M_IDLE;
                        txBusy <= 1'b0;
                        txDone <= 1'b0;
                    end
                end
                default: mst <= M_IDLE;
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Continuous protocol monitors, checked at the end.
    int   onehotViol = 0;
    int   startStopViol = 0;
    int   dblViol = 0;
    int   fsTotal = 0;
    logic pending = 1'b0;

    always @(negedge clk) begin
        if ($countones(reqReady) > 1) onehotViol <= onehotViol + 1;
        if (txStart && mst == M_STOP) startStopViol <= startStopViol + 1;
        if (frameSent) fsTotal <= fsTotal + 1;
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (reqReady != 4'b0) begin
            if (pending) dblViol <= dblViol + 1;
            pending <= 1'b1;
        end else if (frameSent || timeoutErr) begin
            pending <= 1'b0;
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] bytes [4];

    task automatic drive_data();
        reqData = {bytes[3], bytes[2], bytes[1], bytes[0]};
    endtask

    function automatic int idx_of(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic wait_ready(input string tag, input int limit);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < limit; n++) begin
            tick();
            if (reqReady != 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " accept seen"}, 32'(ok), 32'd1);
    endtask

    task automatic wait_inactive(input string tag, input int limit);
        for (int n = 0; n < limit && active; n++) tick();
        check({tag, " active low"}, 32'(active), 32'd0);
    endtask

    initial begin
        int expOrder [8];
        int idx, cnt, fsCnt, fallCyc, nIntv, tA, teCnt, teFirst, enLow, fsBefore;
        logic pb, ps, g2;
        logic [7:0] g2data;
        logic [1:0] g2id;

        expOrder = '{0, 1, 2, 3, 0, 1, 2, 3};

        // ---- reset state ----
        #1 rst_n = 1'b0;
        #2;
        check("rst txEn", 32'(txEn), 32'd0);
        check("rst txStart", 32'(txStart), 32'd0);
        check("rst txData", 32'(txData), 32'd0);
        check("rst reqReady", 32'(reqReady), 32'd0);
        check("rst grantId", 32'(grantId), 32'd0);
        check("rst active", 32'(active), 32'd0);
        check("rst frameSent", 32'(frameSent), 32'd0);
        check("rst timeoutErr", 32'(timeoutErr), 32'd0);
        tick();
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("txEn first edge", 32'(txEn), 32'd1);
        check("no launch without request", 32'(txStart), 32'd0);

        // ---- round robin with all four requesters ----
        bytes = '{8'h10, 8'h20, 8'h30, 8'h40};
        drive_data();
        reqValid = 4'hF;
        for (int g = 0; g < 8; g++) begin
            wait_ready("rr", 60);
            idx = idx_of(reqReady);
            check("rr order", 32'(idx), 32'(expOrder[g]));
            check("rr grantId", 32'(grantId), 32'(expOrder[g]));
            if (idx >= 0) begin
                check("rr txData", 32'(txData), 32'(bytes[idx]));
                bytes[idx] = bytes[idx] + 8'h01;
                drive_data();
                if (g >= 4) reqValid[idx] = 1'b0;
            end
        end
        wait_inactive("rr", 60);

        // ---- single requester 2 ----
        bytes[2] = 8'hA5;
        drive_data();
        reqValid = 4'b0100;
        wait_ready("single", 20);
        check("single reqReady", 32'(reqReady), 32'h4);
        check("single grantId", 32'(grantId), 32'd2);
        check("single txData", 32'(txData), 32'hA5);
        check("single txStart at accept", 32'(txStart), 32'd1);
        check("single active", 32'(active), 32'd1);
        reqValid = 4'b0;
        cnt = 1;
        fsCnt = 0;
        for (int n = 0; n < 20 && txStart; n++) begin
            tick();
            if (txStart) cnt++;
            if (n == 0) check("single ready one cycle", 32'(reqReady), 32'd0);
        end
        // accept edge, model samples start, model raises busy, arbiter sees busy
        check("single txStart cycles", 32'(cnt), 32'd3);
        for (int n = 0; n < 60 && active; n++) begin
            if (frameSent) fsCnt++;
            tick();
        end
        check("single frameSent count", 32'(fsCnt), 32'd1);
        check("single active low", 32'(active), 32'd0);
        check("single txData held", 32'(txData), 32'hA5);

        // ---- gap timing with requester 0 held ----
        // Busy visibly falls, one edge for the arbiter to sample it low,
        // GAP counted edges, then one IDLE edge that launches: GAP+2.
        bytes[0] = 8'h5A;
        drive_data();
        reqValid = 4'b0001;
        fallCyc = -1;
        nIntv = 0;
        pb = txBusy;
        ps = txStart;
        for (int n = 0; n < 200 && nIntv < 2; n++) begin
            tick();
            if (pb && !txBusy) fallCyc = cyc;
            if (!ps && txStart && fallCyc >= 0) begin
                check("gap busy-to-start", 32'(cyc - fallCyc), 32'(GAP + 2));
                check("gap grant", 32'(grantId), 32'd0);
                nIntv++;
                fallCyc = -1;
                if (nIntv == 2) reqValid = 4'b0;
            end
            pb = txBusy;
            ps = txStart;
        end
        check("gap intervals seen", 32'(nIntv), 32'd2);
        wait_inactive("gap", 60);

        // ---- stuck transmitter ----
        stuck = 1'b1;
        bytes[1] = 8'h3C;
        bytes[2] = 8'hC7;
        drive_data();
        reqValid = 4'b0010;
        wait_ready("stuck", 20);
        check("stuck grantId", 32'(grantId), 32'd1);
        tA = cyc;
        reqValid = 4'b0100;
        teCnt = 0;
        teFirst = -1;
        enLow = 0;
        fsCnt = 0;
        g2 = 1'b0;
        g2data = '0;
        g2id = '0;
        for (int n = 0; n < 45; n++) begin
            tick();
            if (timeoutErr) begin
                teCnt++;
                if (teFirst < 0) teFirst = cyc - tA;
                stuck = 1'b0;
            end
            if (!txEn) enLow++;
            if (frameSent) fsCnt++;
            if (reqReady[2]) begin
                g2 = 1'b1;
                g2data = txData;
                g2id = grantId;
                reqValid[2] = 1'b0;
            end
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        check("tmo pulses", 32'(teCnt), 32'd1);
        check("tmo latency", 32'(teFirst), 32'(TMO));
        check("tmo txEn low cycles", 32'(enLow), 32'd1);
        check("tmo no frameSent", 32'(fsCnt), 32'd0);
        check("tmo next granted", 32'(g2), 32'd1);
        check("tmo next grantId", 32'(g2id), 32'd2);
        check("tmo next txData", 32'(g2data), 32'hC7);
`else
        check("stuck no timeoutErr", 32'(teCnt), 32'd0);
        check("stuck txEn held", 32'(enLow), 32'd0);
        check("stuck no frameSent", 32'(fsCnt), 32'd0);
        check("stuck still active", 32'(active), 32'd1);
        check("stuck txStart low", 32'(txStart), 32'd0);
        check("stuck no further grant", 32'(g2), 32'd0);
`endif
        stuck = 1'b0;
        reqValid = 4'b0;

        // ---- reset mid-frame ----
        @(negedge clk) rst_n = 1'b0;
        tick();
        @(negedge clk) rst_n = 1'b1;
        bytes[0] = 8'h11;
        drive_data();
        reqValid = 4'b0001;
        wait_ready("midrst", 20);
        check("midrst first grant", 32'(grantId), 32'd0);
        reqValid = 4'b0;
        for (int n = 0; n < 20 && !(mst == M_DATA && bitcnt == 3'd3); n++) tick();
        check("midrst reached data bit", 32'(mst == M_DATA && bitcnt == 3'd3), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst async txEn", 32'(txEn), 32'd0);
        check("midrst async txStart", 32'(txStart), 32'd0);
        check("midrst async active", 32'(active), 32'd0);
        fsBefore = fsTotal;
        bytes[0] = 8'hC3;
        bytes[3] = 8'h3F;
        drive_data();
        reqValid = 4'b1001;
        tick();
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("midrst txEn first edge", 32'(txEn), 32'd1);
        check("midrst grant from ptr 0", 32'(reqReady), 32'h1);
        check("midrst txData", 32'(txData), 32'hC3);
        check("midrst no frameSent for lost frame", 32'(fsTotal), 32'(fsBefore));
        reqValid = 4'b1000;
        wait_ready("midrst second", 40);
        check("midrst second grantId", 32'(grantId), 32'd3);
        reqValid = 4'b0;
        wait_inactive("midrst", 60);

        // ---- monitors ----
        check("reqReady one-hot", 32'(onehotViol), 32'd0);
        check("txStart in stop state", 32'(startStopViol), 32'd0);
        check("two accepts in one frame", 32'(dblViol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
